cnn_line_window_buffer: RTL

CNN_LINE_WINDOW_BUFFER -- requirements
Module: cnn_line_window_buffer

---
 rtl/cnn_line_window_buffer_pkg.sv | 15 +
 rtl/cnn_defines.sv | 11 +
 rtl/cnn_line_ram.sv | 35 +++
 rtl/cnn_line_window_buffer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/cnn_line_window_buffer_pkg.sv
// Package for the line/window buffer: window-height limits and a helper that
// gives the number of line stores a K-row window needs.
package cnn_line_window_buffer_pkg;

  localparam int WIN_K_MIN = 2;
  localparam int WIN_K_MAX = 8;

  // A K-row window keeps K-1 previous lines; K is clamped to the legal range.
  function automatic int line_store_count(input int k);
    if (k < WIN_K_MIN) return WIN_K_MIN - 1;
    if (k > WIN_K_MAX) return WIN_K_MAX - 1;
    return k - 1;
  endfunction

endpackage

// File: rtl/cnn_defines.sv
// Shared CNN datapath defines.
//   CNN_DATA_IN_W       : default pixel width entering the CNN front end.
//   CNN_LINE_ADDR_W(n)  : address width for a line store holding n pixels
//                         (never narrower than one bit).
`ifndef CNN_DEFINES_SV
`define CNN_DEFINES_SV

`define CNN_DATA_IN_W 8
`define CNN_LINE_ADDR_W(n) (((n) > 1) ? $clog2(n) : 1)

`endif

// File: rtl/cnn_line_ram.sv
// Single-clock line store, DATA_W x IMG_W, read-first.
// The read returns the word held at addr before this cycle's write lands, so a
// store can read and overwrite the same address in one accept cycle; that old
// word is what the next store in the chain writes (line shift).
// Ports:
//   clk   : clock, write on rising edge
//   w_en  : write din to addr on this edge
//   r_en  : read enable; dout is zero when low
//   addr  : shared read/write address
//   din   : write data
//   dout  : pre-write contents of addr
// Contents are deliberately not reset.
`include "cnn_defines.sv"

module cnn_line_ram #(
  parameter int DATA_W = `CNN_DATA_IN_W,
  parameter int IMG_W  = 25
) (
  input  logic                               clk,
  input  logic                               w_en,
  input  logic                               r_en,
  input  logic [`CNN_LINE_ADDR_W(IMG_W)-1:0] addr,
  input  logic [DATA_W-1:0]                  din,
  output logic [DATA_W-1:0]                  dout
);

  logic [DATA_W-1:0] mem [IMG_W];

  always_ff @(posedge clk) begin
    if (w_en) mem[addr] <= din;
  end

  assign dout = r_en ? mem[addr] : '0;

endmodule

// File: rtl/cnn_line_window_buffer.sv
// CNN line/window buffer: takes pixels in raster order and emits one K-row
// window column per accepted pixel once K-1 full lines of the current frame
// have been seen.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : input handshake
//   in_data, in_sof       : pixel, first pixel of a new frame
//   out_valid/out_ready   : output handshake (single output stage, no skid)
//   out_col               : [DATA_W-1:0] current row, slice i = i rows above
//   out_x, out_eol        : column index of out_col, last column of the line
`include "cnn_defines.sv"

module cnn_line_window_buffer
  import cnn_line_window_buffer_pkg::*;
#(
  parameter int DATA_W = `CNN_DATA_IN_W,
  parameter int IMG_W  = 25,
  parameter int K      = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_W-1:0]                  in_data,
  input  logic                               in_sof,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [K*DATA_W-1:0]                out_col,
  output logic [`CNN_LINE_ADDR_W(IMG_W)-1:0] out_x,
  output logic                               out_eol
);

  localparam int AW     = `CNN_LINE_ADDR_W(IMG_W);
  localparam int YW     = $clog2(K);
  localparam int NSTORE = line_store_count(K);
  localparam logic [AW-1:0] X_LAST = AW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(K - 1);
  localparam logic [YW-1:0] Y_ARM  = YW'(K - 2);

  typedef enum logic {PRIME, STREAM} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     x, x_pix, x_nxt;
  logic [YW-1:0]     y, y_pix, y_nxt;
  logic              accept, line_wrap;
  logic [K*DATA_W-1:0] col_nxt, col_p0;
  logic [AW-1:0]     x_p0;
  logic              vld_p0;
  logic [DATA_W-1:0] ram_din  [NSTORE];
  logic [DATA_W-1:0] ram_dout [NSTORE];

  function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
    return (v == Y_LAST) ? Y_LAST : v + 1'b1;
  endfunction

  assign in_ready = !vld_p0 || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame pixel is placed at (0,0) regardless of the counters.
  assign x_pix     = in_sof ? '0 : x;
  assign y_pix     = in_sof ? '0 : y;
  assign line_wrap = (x_pix == X_LAST);

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    if (accept) begin
      x_nxt = line_wrap ? '0 : x_pix + 1'b1;
      y_nxt = line_wrap ? sat_inc_y(y_pix) : y_pix;
      if (in_sof)
        state_nxt = PRIME;
      else if (state == PRIME && line_wrap && y_pix == Y_ARM)
        state_nxt = STREAM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= PRIME;
      x      <= '0;
      y      <= '0;
      vld_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      if (accept)
        vld_p0 <= (state == STREAM) && !in_sof;
      else if (out_ready)
        vld_p0 <= 1'b0;
    end
  end

  // Line stores: store 0 takes the new pixel, store g takes what store g-1
  // held at this column, so store g always holds the line g+1 rows above.
  for (genvar g = 0; g < NSTORE; g++) begin : g_store
    if (g == 0) begin : g_head
      assign ram_din[g] = in_data;
    end else begin : g_chain
      assign ram_din[g] = ram_dout[g-1];
    end
    cnn_line_ram #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W)
    ) u_line_ram (
      .clk  (clk),
      .w_en (accept),
      .r_en (accept),
      .addr (x_pix),
      .din  (ram_din[g]),
      .dout (ram_dout[g])
    );
  end

  always_comb begin
    col_nxt = '0;
    col_nxt[DATA_W-1:0] = in_data;
    for (int j = 0; j < NSTORE; j++)
      col_nxt[(j+1)*DATA_W +: DATA_W] = ram_dout[j];
  end

  // ---- stage p0: output column register ----
  always_ff @(posedge clk) begin
    if (accept) begin
      col_p0 <= col_nxt;
      x_p0   <= x_pix;
    end
  end

  // Data registers carry no reset; gating with the valid flag keeps the
  // outputs zero after reset and hides stale contents while priming.
  assign out_valid = vld_p0;
  assign out_col   = vld_p0 ? col_p0 : '0;
  assign out_x     = vld_p0 ? x_p0 : '0;
  assign out_eol   = vld_p0 && (x_p0 == X_LAST);

endmodule
